// File: rtl/hue_wheel_pkg.sv
// Shared types and helpers for the hue wheel duty generator.
package hue_pkg;

    typedef enum logic [2:0] {
        SEC_R_Y = 3'd0,
        SEC_Y_G = 3'd1,
        SEC_G_C = 3'd2,
        SEC_C_B = 3'd3,
        SEC_B_M = 3'd4,
        SEC_M_R = 3'd5
    } sector_t;

    // Duty must hold the full-scale value PWM_INTERVAL itself, hence the extra bit.
    function automatic int duty_width(input int pwm_interval);
        return $clog2(pwm_interval) + 1;
    endfunction

endpackage

// File: rtl/hue_wheel_if.sv
// Duty/sector bundle between the hue wheel and its consumers.
interface hue_wheel_if #(
    parameter int DUTY_W = 12
);
    logic              enable;
    logic [DUTY_W-1:0] red_duty;
    logic [DUTY_W-1:0] green_duty;
    logic [DUTY_W-1:0] blue_duty;
    logic [2:0]        sector;
    logic              sector_start;

    modport master (
        input  enable,
        output red_duty,
        output green_duty,
        output blue_duty,
        output sector,
        output sector_start
    );

    modport slave (
        output enable,
        input  red_duty,
        input  green_duty,
        input  blue_duty,
        input  sector,
        input  sector_start
    );
endinterface

// File: rtl/hue_wheel_step_timer.sv
// Free-running step prescaler: one tick every STEP_CYCLES enabled clocks.
module step_timer #(
    parameter int STEP_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(STEP_CYCLES - 1);

    if (STEP_CYCLES < 1) begin : g_bad_cycles
        $error("step_timer: STEP_CYCLES must be at least 1");
    end

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    always_comb begin
        tick   = enable && (pcnt_q == PCNT_LAST);
        pcnt_d = pcnt_q;
        if (tick) begin
            pcnt_d = '0;
        end else if (enable) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // Holding the count while disabled means no partial step is lost on resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/hue_wheel.sv
// Hue-circle walker: sector FSM plus ramp register, decoded into RGB duty values.
// sector: 0 R->Y | 1 Y->G | 2 G->C | 3 C->B | 4 B->M | 5 M->R (each ramps one channel)
module hue_wheel
    import hue_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_SIZE    = 8,
    parameter int STEP_CYCLES  = 10000
) (
    input  logic        clk,
    input  logic        rst,
    hue_wheel_if.master bus
);

    localparam int DUTY_W = duty_width(PWM_INTERVAL);
    localparam logic [DUTY_W-1:0] FULL      = DUTY_W'(PWM_INTERVAL);
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(STEP_SIZE);
    localparam logic [DUTY_W-1:0] RAMP_LAST = DUTY_W'(PWM_INTERVAL - STEP_SIZE);

    if (STEP_SIZE < 1 || PWM_INTERVAL < STEP_SIZE || (PWM_INTERVAL % STEP_SIZE) != 0) begin : g_bad_step
        $error("hue_wheel: PWM_INTERVAL must be a positive multiple of STEP_SIZE");
    end

    if ($bits(bus.red_duty) != DUTY_W) begin : g_bad_width
        $error("hue_wheel: interface DUTY_W does not match PWM_INTERVAL");
    end

    logic              tick;
    sector_t           sector_q;
    sector_t           sector_d;
    logic [DUTY_W-1:0] ramp_q;
    logic [DUTY_W-1:0] ramp_d;
    logic              sector_start_q;
    logic              sector_start_d;
    logic [DUTY_W-1:0] up;
    logic [DUTY_W-1:0] down;
    logic [DUTY_W-1:0] red_duty;
    logic [DUTY_W-1:0] green_duty;
    logic [DUTY_W-1:0] blue_duty;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sector_q       <= SEC_R_Y;
            ramp_q         <= '0;
            sector_start_q <= 1'b0;
        end else begin
            sector_q       <= sector_d;
            ramp_q         <= ramp_d;
            sector_start_q <= sector_start_d;
        end
    end

    // The ramp never reaches FULL itself; the next sector's start provides that value.
    always_comb begin
        sector_d       = sector_q;
        ramp_d         = ramp_q;
        sector_start_d = 1'b0;
        if (tick) begin
            if (ramp_q == RAMP_LAST) begin
                ramp_d         = '0;
                sector_start_d = 1'b1;
                sector_d       = (sector_q == SEC_M_R) ? SEC_R_Y : sector_t'(sector_q + 3'd1);
            end else begin
                ramp_d = ramp_q + STEP;
            end
        end
    end

    always_comb begin
        up         = ramp_q;
        down       = FULL - ramp_q;
        red_duty   = '0;
        green_duty = '0;
        blue_duty  = '0;
        unique case (sector_q)
            SEC_R_Y: begin red_duty = FULL; green_duty = up;   end
            SEC_Y_G: begin red_duty = down; green_duty = FULL; end
            SEC_G_C: begin green_duty = FULL; blue_duty = up;  end
            SEC_C_B: begin green_duty = down; blue_duty = FULL; end
            SEC_B_M: begin red_duty = up;   blue_duty = FULL;  end
            SEC_M_R: begin red_duty = FULL; blue_duty = down;  end
            default: begin red_duty = FULL; end
        endcase
    end

    assign bus.red_duty     = red_duty;
    assign bus.green_duty   = green_duty;
    assign bus.blue_duty    = blue_duty;
    assign bus.sector       = sector_q;
    assign bus.sector_start = sector_start_q;

endmodule

// File: tb/tb_hue_wheel.sv
// Self-checking bench for hue_wheel: hue-position reference model plus directed pins and random enable/reset.
module tb_hue_wheel;

    localparam int M  = 16;
    localparam int SS = 4;
    localparam int SC = 4;
    localparam int N  = M / SS;
    localparam int DW = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hue_wheel_if #(.DUTY_W(DW)) bus ();

    hue_wheel #(
        .PWM_INTERVAL (M),
        .STEP_SIZE    (SS),
        .STEP_CYCLES  (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model tracks the absolute step count around the wheel, not sector/ramp.
    int k           = 0;
    int pcnt_m      = 0;
    bit ss_m        = 0;
    bit model_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            k           = 0;
            pcnt_m      = 0;
            ss_m        = 0;
            model_valid = 1;
        end else if (model_valid) begin
            ss_m = 0;
            if (bus.enable) begin
                if (pcnt_m == SC - 1) begin
                    pcnt_m = 0;
                    k      = (k + 1) % (6 * N);
                    ss_m   = (k % N) == 0;
                end else begin
                    pcnt_m++;
                end
            end
        end
    end

    // Channel brightness as a trapezoid around its hue centre on a 6*M circle.
    function automatic int chan(input int h, input int center);
        int d;
        d = h - center;
        if (d < 0) d = -d;
        if (d > 3 * M) d = 6 * M - d;
        if (d <= M) return M;
        if (d >= 2 * M) return 0;
        return 2 * M - d;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            int h, r, g, b, mx, mn;
            h = k * SS;
            r = int'(bus.red_duty);
            g = int'(bus.green_duty);
            b = int'(bus.blue_duty);
            check("model_red",   r, chan(h, 0));
            check("model_green", g, chan(h, 2 * M));
            check("model_blue",  b, chan(h, 4 * M));
            check("model_sector", int'(bus.sector), k / N);
            check("model_sector_start", int'(bus.sector_start), int'(ss_m));
            mx = (r > g) ? r : g;
            mx = (mx > b) ? mx : b;
            mn = (r < g) ? r : g;
            mn = (mn < b) ? mn : b;
            check("invariant_max", mx, M);
            check("invariant_min", mn, 0);
        end
    end

    task automatic expect_rgb(input string tag, input int s, input int r, input int g, input int b);
        check({tag, "_sector"}, int'(bus.sector), s);
        check({tag, "_red"},    int'(bus.red_duty), r);
        check({tag, "_green"},  int'(bus.green_duty), g);
        check({tag, "_blue"},   int'(bus.blue_duty), b);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_rgb("reset_pulse", 0, M, 0, 0);
        check("reset_pulse_ss", int'(bus.sector_start), 0);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_rgb("after_reset", 0, M, 0, 0);
        check("after_reset_ss", int'(bus.sector_start), 0);

        pulses = 0;
        for (int i = 1; i <= 96; i++) begin
            @(negedge clk);
            if (bus.sector_start) pulses++;
            case (i)
                3:  check("first_step_early", int'(bus.green_duty), 0);
                4:  check("first_step", int'(bus.green_duty), 4);
                16: begin
                    expect_rgb("sector1", 1, M, M, 0);
                    check("sector1_ss", int'(bus.sector_start), 1);
                end
                17: check("sector1_ss_drop", int'(bus.sector_start), 0);
                20: check("sector1_r12", int'(bus.red_duty), 12);
                24: check("sector1_r8", int'(bus.red_duty), 8);
                28: check("sector1_r4", int'(bus.red_duty), 4);
                96: expect_rgb("full_wheel", 0, M, 0, 0);
                default: ;
            endcase
        end
        check("pulse_count", pulses, 6);

        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        repeat (10) @(negedge clk);
        expect_rgb("frozen", 0, M, 0, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        check("resume_hold", int'(bus.green_duty), 0);
        @(negedge clk);
        check("resume_tick", int'(bus.green_duty), 4);

        pulse_reset();
        repeat (56) @(negedge clk);
        expect_rgb("sector3_ramp8", 3, 0, 8, M);
        pulse_reset();
        for (int i = 1; i <= 96; i++) begin
            @(negedge clk);
            case (i)
                4:  check("restart_step", int'(bus.green_duty), 4);
                92: expect_rgb("sector5_ramp12", 5, M, 0, 4);
                96: begin
                    expect_rgb("wrap", 0, M, 0, 0);
                    check("wrap_ss", int'(bus.sector_start), 1);
                end
                default: ;
            endcase
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.enable = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
